// File: rtl/cb_pkg.sv
// ============================================================================
// cb_pkg : shared types and constants for the contrastBrightness sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cb_pkg;

  localparam int PIX_W = 24;

  // {R,G,B} field boundaries of a packed pixel
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [PIX_W-1:0] pack_rgb(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cb_valid_delay.sv
// ============================================================================
// cb_valid_delay : DEPTH-stage valid shift register with occupancy flag
// Rev 1.0
// ============================================================================
`default_nettype none

module cb_valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_valid,
  output logic o_any_valid
);

  logic [DEPTH-1:0] r_shift;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_shift <= '0;
        else        r_shift <= i_valid;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_shift <= '0;
        else        r_shift <= {r_shift[DEPTH-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid     = r_shift[DEPTH-1];
  assign o_any_valid = |r_shift;

endmodule

`default_nettype wire

// File: rtl/cb_frame_sequencer.sv
// ============================================================================
// cb_frame_sequencer : walks the source frame, feeds contrastBrightness and
// writes adjusted pixels to the destination buffer in order.   Rev 1.0
// ============================================================================
`default_nettype none

module cb_frame_sequencer
  import cb_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 2,
  parameter int CB_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              grant,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  cb_in,
  input  logic [PIX_W-1:0]  cb_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int                N_PIX     = WIDTH * HEIGHT;
  localparam int                DEPTH     = RD_LAT + CB_LAT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_any_valid;
  logic              w_start_ok;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_rd_fire  = (r_state == RUN) && grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_rd_fire && (r_rd_addr == LAST_ADDR)) w_next = DRAIN;
      // any_valid covers the output stage too, so no write is left pending
      DRAIN:   if (!w_any_valid) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with r_state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else if (w_start_ok) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else begin
      if (w_rd_fire && (r_rd_addr != LAST_ADDR)) r_rd_addr <= r_rd_addr + 1'b1;
      if (w_wr_fire)                             r_wr_addr <= r_wr_addr + 1'b1;
    end
  end

  cb_valid_delay #(
    .DEPTH (DEPTH)
  ) u_valid_delay (
    .clk         (clk),
    .rst_n       (reset),
    .i_valid     (w_rd_fire),
    .o_valid     (w_wr_fire),
    .o_any_valid (w_any_valid)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = w_rd_fire;
  assign rd_addr = r_rd_addr;
  assign cb_in   = rd_data;
  assign wr_en   = w_wr_fire;
  assign wr_addr = r_wr_addr;
  assign wr_data = w_wr_fire ? cb_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_cb_frame_sequencer.sv
// ============================================================================
// tb_cb_frame_sequencer : randomized frames against a frame-level reference
// model with a write/pixel scoreboard.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_cb_frame_sequencer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 2;
  localparam int CB_LAT = 1;
  localparam int N      = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              grant;
  logic              busy, done, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [23:0]       rd_data, cb_in, wr_data;
  logic [23:0]       cb_out_r;

  cb_frame_sequencer #(
    .WIDTH (WIDTH), .HEIGHT (HEIGHT), .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT), .CB_LAT (CB_LAT)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .grant (grant),
    .busy (busy), .done (done), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data), .cb_in (cb_in), .cb_out (cb_out_r),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // source memory with RD_LAT read latency, and a one-cycle pass-through CB
  logic [23:0] mem [N];
  logic [23:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= rd_en ? mem[rd_addr] : 24'h0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    cb_out_r <= cb_in;
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int addr; logic [23:0] data; int cyc; } wexp_t;
  typedef struct { logic [23:0] data; int cyc; } cexp_t;
  wexp_t wq[$];
  cexp_t cq[$];

  // frame-level model: phase 0 idle, 1 issuing reads, 2 waiting for done
  int phase   = 0;
  int reads   = 0;
  int done_at = 0;
  int idle_rd = 0;
  int idle_wr = 0;
  int wr_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      phase = 0; idle_rd = 0; idle_wr = 0;
      wq.delete(); cq.delete();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
    end else begin
      chk("busy", busy, phase != 0);
      chk("done", done, (phase == 2) && (cyc == done_at));
      chk("rd_en", rd_en, (phase == 1) && grant);
      if (phase == 1 && grant) begin
        chk("rd_addr", rd_addr, reads);
        wq.push_back('{addr: reads, data: mem[reads], cyc: cyc + RD_LAT + CB_LAT});
        cq.push_back('{data: mem[reads], cyc: cyc + RD_LAT});
        reads++;
        if (reads == N) begin
          phase   = 2;
          done_at = cyc + RD_LAT + CB_LAT + 2;
        end
      end else if (phase == 0) begin
        chk("idle_wr_en", wr_en, 0);
        chk("idle_rd_addr", rd_addr, idle_rd);
        chk("idle_wr_addr", wr_addr, idle_wr);
        chk("idle_wr_data", wr_data, 0);
        if (start) begin
          phase = 1;
          reads = 0;
        end
      end else if (phase == 2 && cyc == done_at) begin
        chk("end_rd_addr", rd_addr, N - 1);
        chk("end_wr_addr", wr_addr, N);
        phase = 0; idle_rd = N - 1; idle_wr = N;
      end
    end
  end

  // scoreboard: pixels on cb_in and destination writes
  always @(negedge clk) begin
    if (reset) begin
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        chk("cb_in", cb_in, cq[0].data);
        void'(cq.pop_front());
      end
      if (wr_en) begin
        wr_seen++;
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        chk("missing_write", 0, 1);
        void'(wq.pop_front());
      end
    end
  end

  task automatic run_frame(input int mode, input bit repulse, input bit pix5);
    bit got;
    got = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    if (pix5) mem[5] = 24'hC0C0C0;
    @(posedge clk); #1;
    start = 1'b1;
    grant = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      case (mode)
        0:       grant = 1'b1;
        1:       grant = (i % 2 == 0);
        default: grant = 1'($urandom_range(0, 1));
      endcase
      start = repulse && (i == 3 || i == 9 || i == 10);
      @(negedge clk); #1;
      if (done) got = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    grant = 1'b0;
    chk("frame_done_seen", got, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic abort_frame();
    int  base;
    bit  hit;
    base = wr_seen;
    hit  = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    grant = 1'b1;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk); #1;
      if (wr_seen >= base + 3) hit = 1'b1;
    end
    chk("abort_three_writes", hit, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_wr_data", wr_data, 0);
    grant = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    grant = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    run_frame(0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1);
    abort_frame();
    run_frame(0, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b0);
    run_frame(1, 1'b1, 1'b1);
    chk("queues_empty", wq.size() + cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/cb_frame_sequencer.md
# cb_frame_sequencer

Frame-level controller for the contrastBrightness pixel datapath in the colorReduction pipeline. On a start pulse it walks the source frame buffer linearly and issues one read per granted cycle. It presents each returned pixel to contrastBrightness, tracks validity through the datapath's fixed latency, and writes every adjusted pixel to the destination buffer in order. It then reports completion with a single-cycle done pulse.

## Interface
Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- ADDR_W, 19, buffer address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- RD_LAT, 2, source-buffer read latency in cycles (≥1)
- CB_LAT, 1, contrastBrightness latency in cycles, tRGB to uptRGB (≥0)

Ports:
- clk  in  1  single system clock; all logic rising-edge
- reset  in  1  asynchronous, active-low: 0 resets immediately, release synchronous to clk
- start  in  1  begin frame; sampled only in IDLE
- grant  in  1  source-buffer access granted this cycle (shared with VGA readout)
- busy  out  1  high from RUN entry until DONE exit
- done  out  1  one-cycle pulse at frame completion
- rd_en  out  1  source read strobe
- rd_addr  out  ADDR_W  source address
- rd_data  in  24  source pixel {R,G,B}, valid RD_LAT cycles after rd_en
- cb_in  out  24  to contrastBrightness tRGB
- cb_out  in  24  from contrastBrightness uptRGB
- wr_en  out  1  destination write strobe
- wr_addr  out  ADDR_W  destination address
- wr_data  out  24  adjusted pixel

## Operation
- N = WIDTH*HEIGHT; LAST = N-1.
- States:
  - IDLE: start=1 → RUN; rd_addr←0, wr_addr←0.
  - RUN: each cycle with grant=1, drive rd_en=1 with the current rd_addr. If rd_addr==LAST → DRAIN, else rd_addr+1. With grant=0, rd_en=0 and nothing advances.
  - DRAIN: the valid delay line holds in-flight pixels; go to DONE when it is empty and no write is pending.
  - DONE: done=1 for exactly one cycle → IDLE.
- cb_in = rd_data as a wire; contrastBrightness is fed directly.
- A valid bit enters a delay line of depth RD_LAT+CB_LAT on each rd_en. At its output: wr_en=1, wr_data=cb_out, and wr_addr increments after the write.
- The destination side always accepts; there is no write backpressure.
- start while busy is ignored; grant is ignored outside RUN.
- Counters never wrap within a frame. rd_addr stops at LAST, and wr_addr ends at N after the last write.
- Reset asserted mid-frame aborts immediately: state→IDLE, delay line cleared, no done pulse. The partially written frame is left as is.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE.
- start sampled at edge t → busy=1 and first possible rd_en at t+1.
- Read issued at cycle c → wr_en at cycle c+RD_LAT+CB_LAT with wr_addr equal to that read's address.
- With grant held high, the frame takes N + RD_LAT + CB_LAT + 2 cycles from start to the done pulse.
- rd_en and wr_en may be high in the same cycle, including the last read concurrently with an earlier write.
- done and busy are registered outputs; busy falls in the cycle after done.

## Structure
- Shared package cb_pkg holds PIX_W=24, the state enum (IDLE, RUN, DRAIN, DONE), and the {R,G,B} field slice constants used by contrastBrightness.
- One sub-module, cb_valid_delay, is a parameterised DEPTH-stage shift register of valid bits. It has an async active-low clear and an any_valid output used for the DRAIN exit.
- contrastBrightness is instantiated by the parent, not inside this block.

## Test plan
Bench: WIDTH=4, HEIGHT=2, RD_LAT=2, CB_LAT=1, with a behavioural memory model and a pass-through CB model delayed one cycle.
- Reset, then hold all inputs low → every output at 0 and state IDLE for 20 cycles.
- start pulse, grant=1 continuous → 8 writes at addresses 0..7, with wr_data matching the model. done pulses once at cycle 8+2+1+2=13 after start.
- grant toggling 1,0,1,0… → reads stall on the 0 cycles. Writes stay in order at 0..7, done arrives after 8 granted cycles plus drain, and there are no duplicate addresses.
- start re-pulsed while busy → ignored: exactly 8 writes and one done.
- reset dropped to 0 after 3 writes → outputs zero immediately, no done. A following start produces a full clean frame from address 0.
- Pixel {192,192,192} at address 5 → appears on cb_in at read+2 and on wr_data with wr_addr=5 at read+3.
